// File: rtl/timer_display_scan_if.sv
// Purpose: BCD time digits in, multiplexed seven-segment drive out.
// Latency: pure signal bundle, no logic and no delay of its own.
// Backpressure: none; the digits are sampled, never acknowledged.
interface timer_display_scan_if;
    logic [3:0] sec_units;
    logic [2:0] sec_tens;
    logic [3:0] min_units;
    logic [2:0] min_tens;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    // Timer side: drives the digits and can observe the display pins.
    modport master (
        output sec_units, sec_tens, min_units, min_tens,
        input  an, seg, dp
    );

    // Scanner side: consumes the digits and drives the display pins.
    modport slave (
        input  sec_units, sec_tens, min_units, min_tens,
        output an, seg, dp
    );
endinterface

// File: rtl/timer_display_scan.sv
// Purpose: scans a 4-digit MM:SS snapshot onto a common-anode 7-seg display.
// Latency: an/seg/dp are registered, one edge behind idx/snap.
// Backpressure: none; the inputs are snapshotted once per frame.
module timer_display_scan #(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1,
    parameter bit DP_BLINK = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    timer_display_scan_if.slave  disp
);
    localparam int            CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    // Layout: {min_tens, min_units, sec_tens, sec_units}
    logic [13:0]   snap;

    logic       frame_start;
    logic [3:0] digit;
    logic       digit_bad;
    logic       digit_blank;
    logic [3:0] an_nxt;
    logic [6:0] seg_nxt;
    logic       dp_nxt;

    assign frame_start = (cnt == '0) && (idx == 2'd0);

    // Pick the active digit from the snapshot and classify it.
    always_comb begin
        digit     = 4'd0;
        digit_bad = 1'b0;
        case (idx)
            2'd0: begin
                digit     = snap[3:0];
                digit_bad = (snap[3:0] > 4'd9);
            end
            2'd1: begin
                digit     = {1'b0, snap[6:4]};
                digit_bad = (snap[6:4] > 3'd5);
            end
            2'd2: begin
                digit     = snap[10:7];
                digit_bad = (snap[10:7] > 4'd9);
            end
            default: begin
                digit     = {1'b0, snap[13:11]};
                digit_bad = (snap[13:11] > 3'd5);
            end
        endcase
        // A zero is always in range, so a blanked digit is never a dash.
        digit_blank = BLANK_LZ && (idx == 2'd3) && (digit == 4'd0);
    end

    // Next-cycle pin values: anode one-hot, segment decode, colon on digit 2.
    always_comb begin
        an_nxt = ~(4'b0001 << idx);
        dp_nxt = ~((idx == 2'd2) && (!DP_BLINK || !snap[0]));
        if (digit_blank) begin
            seg_nxt = 7'b1111111;
        end else if (digit_bad) begin
            seg_nxt = 7'b0111111;
        end else begin
            case (digit)
                4'd0:    seg_nxt = 7'b1000000;
                4'd1:    seg_nxt = 7'b1111001;
                4'd2:    seg_nxt = 7'b0100100;
                4'd3:    seg_nxt = 7'b0110000;
                4'd4:    seg_nxt = 7'b0011001;
                4'd5:    seg_nxt = 7'b0010010;
                4'd6:    seg_nxt = 7'b0000010;
                4'd7:    seg_nxt = 7'b1111000;
                4'd8:    seg_nxt = 7'b0000000;
                4'd9:    seg_nxt = 7'b0010000;
                default: seg_nxt = 7'b0111111;
            endcase
        end
    end

    // Divider, digit index, frame snapshot and registered display pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            idx      <= 2'd0;
            snap     <= '0;
            disp.an  <= 4'b1111;
            disp.seg <= 7'b1111111;
            disp.dp  <= 1'b1;
        end else begin
            if (cnt == CNT_MAX) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            // Single capture per frame keeps a mid-frame carry from tearing.
            if (frame_start) begin
                snap <= {disp.min_tens, disp.min_units, disp.sec_tens, disp.sec_units};
            end
            disp.an  <= an_nxt;
            disp.seg <= seg_nxt;
            disp.dp  <= dp_nxt;
        end
    end
endmodule

// File: doc/timer_display_scan.md
# timer_display_scan

Downstream consumer of the MM:SS hour timer: takes the four BCD digits (`min_tens`, `min_units`, `sec_tens`, `sec_units`) and time-multiplexes them onto a 4-digit common-anode seven-segment display. It takes a coherent snapshot of the digits once per scan frame, so a carry ripple mid-frame never tears the display. It also decodes BCD to segments, blanks the leading minute-tens zero, and drives a blinking colon on the decimal point.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each digit is held active. Legal range is ≥ 2.
- `BLANK_LZ`, default 1: when 1, the min_tens digit is blanked if its snapshot value is 0.
- `DP_BLINK`, default 1: when 1, the colon dp blinks on seconds parity. When 0, the colon dp is lit steadily.
- `clk` input 1: the single clock, shared with the timer.
- `reset` input 1: **synchronous, active-high** reset, same net as the timer's.
- `sec_units` input 4: seconds units, BCD.
- `sec_tens` input 3: seconds tens, BCD.
- `min_units` input 4: minutes units, BCD.
- `min_tens` input 3: minutes tens, BCD.
- `an` output 4: digit enables, active-low, one-hot. `an[0]` is sec_units and `an[3]` is min_tens.
- `seg` output 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `dp` output 1: decimal point, active-low.

## Operation
- **State registers**
  - `cnt` counts 0..SCAN_DIV-1; width is $clog2(SCAN_DIV).
  - `idx` is 2 bits.
  - `snap` is 14 bits (copy of the four inputs).
  - `an`, `seg` and `dp` are registered outputs.
- **Divider:** `cnt` increments every cycle. At SCAN_DIV-1 it wraps to 0, and `idx` advances 0→1→2→3→0 on that same edge.
- **Snapshot:** `snap` loads all four inputs on any cycle where `cnt==0 && idx==0` (start of frame). It holds its value otherwise.
- **Digit select:**
  - idx 0 selects snap sec_units.
  - idx 1 selects snap sec_tens.
  - idx 2 selects snap min_units.
  - idx 3 selects snap min_tens.
- **Enable decode:** `an` is driven as `~(4'b0001 << idx)`.
- **Segment decode (active-low)**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- **Out-of-range values:**
  - A units digit above 9, or a tens digit above 5, shows a dash: `seg`=0111111.
  - Out-of-range digits are never blanked.
- **Leading-zero blanking:** with BLANK_LZ=1, idx 3 with snap min_tens==0 gives `seg`=1111111. `an[3]` still asserts, so the frame timing is unchanged.
- **dp:**
  - Low only when idx==2.
  - If DP_BLINK=1, dp is low only when snap sec_units[0]==0 (lit on even seconds).
  - dp is 1 on all other digits.

## Timing
- **Reset:** `reset` is sampled on the rising edge of `clk`. When it is high at an edge, that edge sets:
  - `cnt`=0, `idx`=0, `snap`=0
  - `an`=1111 (all digits off), `seg`=1111111, `dp`=1
- **Output latency:** outputs are registered from (`idx`, `snap`) with 1 cycle of latency. `an`, `seg` and `dp` change exactly one edge after `idx` or `snap` changes.
- **First edge after reset release:**
  - `snap` loads the live inputs.
  - Outputs show digit 0 from the cleared snapshot: `an`=1110, `seg`=1000000.
  - From the next edge on, outputs show the loaded snapshot. This one-cycle 0 is accepted behaviour.
- **Dwell:** each digit's `an` stays low for exactly SCAN_DIV consecutive cycles. A full frame is 4·SCAN_DIV cycles.
- **Enable rules:**
  - Exactly one `an` bit is low every cycle outside reset, with no overlap and no gap.
  - `an` and `seg` switch on the same edge.
- **Input changes:** a change on the inputs anywhere other than the snapshot-load cycle affects nothing until the next frame start.
- **Simultaneous events:** if an input changes on the exact load cycle, the value present at that edge is the one captured.
- **Reset mid-frame:**
  - Aborts the frame immediately; the edge values above apply.
  - Scanning restarts at idx 0 with a fresh snapshot on the first edge after release.
- **No back-pressure:** there are no handshakes, and the inputs are sampled, never acknowledged.

## Test plan
- **Reset:** SCAN_DIV=4, hold reset for 3 cycles.
  - Required: `an`=1111, `seg`=1111111, `dp`=1 during reset.
  - One edge after release: `an`=1110 and `seg`=1000000.
- **Scan order:** SCAN_DIV=4, inputs static at 12:34.
  - Required: `an` sequence 1110,1101,1011,0111, each held for 4 cycles.
  - Segments in that order: 0011001 (4), 0110000 (3), 0100100 (2), 1111001 (1).
  - Pattern repeats every 16 cycles.
- **Snapshot coherence:** SCAN_DIV=4, inputs 09:59, changed to 10:00 at cycle 6 of a frame.
  - Required: the rest of that frame still shows 9,5,9,0, with min_tens blanked when BLANK_LZ=1.
  - The next frame shows 0,0,0,1.
- **Blanking and dash:**
  - min_tens=0 with BLANK_LZ=1: `seg`=1111111 during `an`=0111.
  - min_tens=0 with BLANK_LZ=0: `seg`=1000000 during `an`=0111.
  - sec_units=4'hC: `seg`=0111111 during `an`=1110.
- **Colon blink:** DP_BLINK=1.
  - sec_units=6: `dp`=0 only during `an`=1011.
  - sec_units=7: `dp`=1 for the whole frame.
  - DP_BLINK=0: `dp`=0 during `an`=1011 regardless of sec_units.
- **Mid-frame reset:** assert reset for 1 cycle while idx=2, cnt=1.
  - Required: `an`=1111 on that edge.
  - Next edge: `an`=1110 with a new snapshot load.
  - Digit 0 is then held for a full SCAN_DIV cycles.
